// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter (LSB first) with a small input FIFO and a
// valid/ready write port.
// Optional feature macro: UART_TX_PARITY_EN appends an even-parity bit after bit 7.
module uart_tx #(
  parameter int unsigned CLK_DIVIDE = 868,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_valid,
  input  logic [7:0]                  i_data,
  output logic                        o_ready,
  output logic                        o_serialOut,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_fifoCount
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(CLK_DIVIDE);
  localparam logic [TW-1:0] T_LAST    = TW'(CLK_DIVIDE - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif
  logic          bit_end;
  logic          line_d, busy_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count_d;
  logic          push, pop;

  assign o_ready = (o_fifoCount != FULL_CNT);
  assign push    = i_valid && o_ready;
  assign bit_end = (timer_q == T_LAST);

  // FIFO storage; contents need no reset, occupancy is tracked separately
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  // Next occupancy: simultaneous push and pop cancel out
  always_comb begin
    count_d = o_fifoCount;
    if (push && !pop)      count_d = o_fifoCount + 1'b1;
    else if (pop && !push) count_d = o_fifoCount - 1'b1;
  end

  // FIFO pointers and occupancy register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_fifoCount <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      o_fifoCount <= count_d;
    end
  end

  // Frame sequencing: bit timer, bit index, shift register and FIFO pop
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q != IDLE) timer_d = bit_end ? '0 : timer_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (o_fifoCount != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
          parity_d = ^mem[rd_ptr];
`endif
          bit_d   = '0;
          timer_d = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (o_fifoCount != '0) begin
              // Back-to-back frames: reload straight into START with no idle bit
              pop     = 1'b1;
              shift_d = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
              parity_d = ^mem[rd_ptr];
`endif
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line and busy are registered from next-state values so the line falls on the pop edge
  always_comb begin
    line_d = 1'b1;
    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_d = parity_d;
`endif
      default: line_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  // State register with registered TX line and busy flag
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
      o_serialOut <= 1'b1;
      o_busy      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
      o_serialOut <= line_d;
      o_busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx (CLK_DIVIDE=8, FIFO_DEPTH=4, STOP_BITS=1).
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int unsigned CD    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SB    = 1;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  localparam int unsigned NBITS = 1 + 8 + PB + SB;
  localparam int unsigned FRAME = NBITS * CD;
  localparam int unsigned LIMIT = 8 * FRAME;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    valid;
  logic [7:0]              data;
  logic                    ready;
  logic                    line;
  logic                    busy;
  logic [$clog2(DEPTH):0]  count;

  int checks   = 0;
  int failures = 0;

  // Captured waveform of one frame, one CD-sample vector per bit slot
  logic [CD-1:0] wave [NBITS];
  logic          busy_drop;

  // Decoded bytes from the serial line
  logic [7:0] rx_q [$];
  int         rx_err;
  logic       rx_timeout;

  always #5 clk = ~clk;

  uart_tx #(.CLK_DIVIDE(CD), .FIFO_DEPTH(DEPTH), .STOP_BITS(SB)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_valid     (valid),
    .i_data      (data),
    .o_ready     (ready),
    .o_serialOut (line),
    .o_busy      (busy),
    .o_fifoCount (count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop ones
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (PB == 1 && i == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic capture_frame();
    busy_drop = 1'b0;
    for (int i = 0; i < int'(NBITS); i++) begin
      for (int c = 0; c < int'(CD); c++) begin
        wave[i][c] = line;
        if (busy !== 1'b1) busy_drop = 1'b1;
        step();
      end
    end
  endtask

  // Mid-bit sampling receiver
  task automatic decode(input int n);
    logic [NBITS-1:0] s;
    logic [7:0] b;
    int w;
    rx_q.delete();
    rx_err = 0;
    rx_timeout = 1'b0;
    for (int f = 0; f < n; f++) begin
      w = 0;
      while (line !== 1'b0 && w < int'(LIMIT)) begin
        step();
        w++;
      end
      if (w >= int'(LIMIT)) begin
        rx_timeout = 1'b1;
        return;
      end
      repeat (CD / 2) step();
      s = '0;
      s[0] = line;
      for (int i = 1; i < int'(NBITS); i++) begin
        repeat (CD) step();
        s[i] = line;
      end
      b = s[8:1];
      for (int i = 0; i < int'(NBITS); i++)
        if (s[i] !== frame_bit(b, i)) rx_err++;
      rx_q.push_back(b);
    end
  endtask

  task automatic wait_idle(output logic timed_out);
    int w = 0;
    while (busy !== 1'b0 && w < int'(LIMIT)) begin
      step();
      w++;
    end
    timed_out = (w >= int'(LIMIT));
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; data = '0;
    #12;
    checks++; if (line !== 1'b1) begin failures++; $display("FAIL reset_line got=%b exp=1", line); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    #1 rst = 1'b0;
    step();
    step();
    checks++; if (line !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle got line=%b busy=%b exp line=1 busy=0", line, busy); end
  endtask

  task automatic test_single(input logic [7:0] b);
    logic [CD-1:0] e;
    valid = 1'b1; data = b;
    step();
    valid = 1'b0;
    checks++; if (line !== 1'b1 || count !== 1 || busy !== 1'b1) begin
      failures++; $display("FAIL single_push_edge byte=%h got line=%b count=%0d busy=%b exp 1/1/1", b, line, count, busy);
    end
    step();
    capture_frame();
    for (int i = 0; i < int'(NBITS); i++) begin
      e = {CD{frame_bit(b, i)}};
      checks++; if (wave[i] !== e) begin failures++; $display("FAIL single_bit byte=%h slot=%0d got=%b exp=%b", b, i, wave[i], e); end
    end
    checks++; if (busy_drop !== 1'b0) begin failures++; $display("FAIL single_busy_held byte=%h got drop=%b exp=0", b, busy_drop); end
    checks++; if (busy !== 1'b0 || line !== 1'b1 || count !== '0) begin
      failures++; $display("FAIL single_end byte=%h got busy=%b line=%b count=%0d exp 0/1/0", b, busy, line, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bq [6];
    int accepted = 0;
    int at_block = -1;
    for (int k = 0; k < 6; k++) bq[k] = 8'($urandom);
    fork
      begin
        int guard = 0;
        logic r;
        while (accepted < 6 && guard < int'(20 * FRAME)) begin
          valid = 1'b1; data = bq[accepted];
          r = ready;
          if (!r && at_block < 0) at_block = accepted;
          step();
          if (r) accepted++;
          guard++;
        end
        valid = 1'b0;
      end
      begin
        logic [CD-1:0] e;
        step();
        step();
        for (int f = 0; f < 6; f++) begin
          capture_frame();
          for (int i = 0; i < int'(NBITS); i++) begin
            e = {CD{frame_bit(bq[f], i)}};
            checks++; if (wave[i] !== e) begin failures++; $display("FAIL b2b_bit frame=%0d slot=%0d got=%b exp=%b", f, i, wave[i], e); end
          end
          checks++; if (busy_drop !== 1'b0) begin failures++; $display("FAIL b2b_busy frame=%0d got drop=1 exp=0", f); end
        end
      end
    join
    checks++; if (at_block !== int'(DEPTH + 1)) begin failures++; $display("FAIL b2b_ready_block got=%0d exp=%0d", at_block, DEPTH + 1); end
    checks++; if (accepted !== 6) begin failures++; $display("FAIL b2b_accepted got=%0d exp=6", accepted); end
    checks++; if (busy !== 1'b0 || line !== 1'b1) begin failures++; $display("FAIL b2b_end got busy=%b line=%b exp 0/1", busy, line); end
  endtask

  task automatic test_fifo_edges();
    logic [7:0] v [7];
    logic to;
    for (int k = 0; k < 7; k++) v[k] = 8'($urandom);
    fork
      decode(6);
      begin
        valid = 1'b1; data = v[0]; step();
        data = v[1]; step();
        data = v[2]; step();
        valid = 1'b0;
        repeat (FRAME - 2) step();
        checks++; if (count !== 2) begin failures++; $display("FAIL pre_pop_count got=%0d exp=2", count); end
        valid = 1'b1; data = v[3];
        step();
        checks++; if (count !== 2) begin failures++; $display("FAIL same_edge_count got=%0d exp=2", count); end
        checks++; if (line !== 1'b0) begin failures++; $display("FAIL zero_gap_start got=%b exp=0", line); end
        data = v[4]; step();
        data = v[5]; step();
        checks++; if (ready !== 1'b0 || count !== DEPTH) begin failures++; $display("FAIL full_state got ready=%b count=%0d exp 0/%0d", ready, count, DEPTH); end
        data = v[6];
        repeat (3) step();
        valid = 1'b0;
        checks++; if (count !== DEPTH) begin failures++; $display("FAIL full_drop_count got=%0d exp=%0d", count, DEPTH); end
      end
    join
    checks++; if (rx_timeout !== 1'b0 || rx_q.size() != 6) begin failures++; $display("FAIL edges_rx_size got=%0d timeout=%b exp=6", rx_q.size(), rx_timeout); end
    for (int k = 0; k < 6 && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== v[k]) begin failures++; $display("FAIL edges_rx_byte idx=%0d got=%h exp=%h", k, rx_q[k], v[k]); end
    end
    checks++; if (rx_err !== 0) begin failures++; $display("FAIL edges_framing got=%0d exp=0", rx_err); end
    wait_idle(to);
    checks++; if (to !== 1'b0 || count !== '0) begin failures++; $display("FAIL edges_drain got timeout=%b count=%0d exp 0/0", to, count); end
  endtask

  task automatic test_reset_mid_frame();
    logic bad_line, bad_busy;
    valid = 1'b1; data = 8'hA3; step();
    data = 8'h3C; step();
    valid = 1'b0;
    repeat (CD + 3 * CD + CD / 2) step();
    checks++; if (line !== frame_bit(8'hA3, 4)) begin failures++; $display("FAIL mid_data_bit3 got=%b exp=%b", line, frame_bit(8'hA3, 4)); end
    checks++; if (count !== 1) begin failures++; $display("FAIL mid_data_count got=%0d exp=1", count); end
    #3 rst = 1'b1;
    #1;
    checks++; if (line !== 1'b1) begin failures++; $display("FAIL async_reset_line got=%b exp=1", line); end
    checks++; if (count !== '0 || ready !== 1'b1) begin failures++; $display("FAIL async_reset_fifo got count=%0d ready=%b exp 0/1", count, ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    bad_line = 1'b0; bad_busy = 1'b0;
    repeat (2 * FRAME) begin
      step();
      if (line !== 1'b1) bad_line = 1'b1;
      if (busy !== 1'b0) bad_busy = 1'b1;
    end
    checks++; if (bad_line !== 1'b0) begin failures++; $display("FAIL reset_release_line got low=1 exp=0"); end
    checks++; if (bad_busy !== 1'b0 || count !== '0) begin failures++; $display("FAIL reset_release_busy got busy_seen=%b count=%0d exp 0/0", bad_busy, count); end
  endtask

  task automatic test_random();
    logic [7:0] b [8];
    logic stuck = 1'b0;
    logic to;
    for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
    fork
      decode(8);
      begin
        for (int k = 0; k < 8; k++) begin
          int g = 0;
          repeat ($urandom_range(0, 2 * FRAME)) step();
          valid = 1'b1; data = b[k];
          while (ready !== 1'b1 && g < int'(4 * FRAME)) begin
            step();
            g++;
          end
          if (g >= int'(4 * FRAME)) stuck = 1'b1;
          step();
          valid = 1'b0;
        end
      end
    join
    checks++; if (stuck !== 1'b0) begin failures++; $display("FAIL random_ready_timeout got=1 exp=0"); end
    checks++; if (rx_timeout !== 1'b0 || rx_q.size() != 8) begin failures++; $display("FAIL random_rx_size got=%0d timeout=%b exp=8", rx_q.size(), rx_timeout); end
    for (int k = 0; k < 8 && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== b[k]) begin failures++; $display("FAIL random_rx_byte idx=%0d got=%h exp=%h", k, rx_q[k], b[k]); end
    end
    checks++; if (rx_err !== 0) begin failures++; $display("FAIL random_framing got=%0d exp=0", rx_err); end
    wait_idle(to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL random_idle_timeout got=1 exp=0"); end
  endtask

  initial begin
    test_reset();
    test_single(8'h55);
    test_single(8'($urandom));
    test_back_to_back();
    test_fifo_edges();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
